// File: rtl/unitate_fetch.sv
// Fetch stage of the 8-bit core: owns the PC, runs one req/gnt/rvalid fetch at a
// time and hands instructions to decode. Define FETCH_CNT_EN to add o_fetch_cnt.
module unitate_fetch #(
  parameter int unsigned          PC_W     = 8,
  parameter int unsigned          INSTR_W  = 16,
  parameter logic [PC_W-1:0]      RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic [PC_W-1:0]    o_pc,
  input  logic [PC_W-1:0]    i_next_pc,
  input  logic               i_restart,
  input  logic [PC_W-1:0]    i_restart_pc,
  output logic               o_imem_req,
  output logic [PC_W-1:0]    o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic               o_instr_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_instr_pc,
  input  logic               i_instr_ready
`ifdef FETCH_CNT_EN
  ,
  output logic [15:0]        o_fetch_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [PC_W-1:0]      r_pc;
  logic [PC_W-1:0]      w_pc_next;
  logic                 r_req;
  logic                 r_valid;
  logic [INSTR_W-1:0]   r_instr;
  logic [PC_W-1:0]      r_instr_pc;
  logic                 w_capture;
  logic                 w_consume;

  // Restart overrides everything; a granted-but-unanswered fetch must be drained.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_consume    = 1'b0;
    if (i_restart) begin
      case (r_state)
        S_REQ:   w_next_state = i_imem_gnt    ? S_DRAIN : S_REQ;
        S_RESP:  w_next_state = i_imem_rvalid ? S_REQ   : S_DRAIN;
        S_DRAIN: w_next_state = i_imem_rvalid ? S_REQ   : S_DRAIN;
        default: w_next_state = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_IDLE: w_next_state = S_REQ;
        S_REQ: begin
          if (i_imem_gnt) begin
            w_next_state = S_RESP;
          end
        end
        S_RESP: begin
          if (i_imem_rvalid) begin
            w_capture    = 1'b1;
            w_next_state = S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_instr_ready) begin
            w_consume    = 1'b1;
            w_next_state = S_REQ;
          end
        end
        S_DRAIN: begin
          if (i_imem_rvalid) begin
            w_next_state = S_REQ;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_pc_next = r_pc;
    if (i_restart) begin
      w_pc_next = i_restart_pc;
    end else if (w_consume) begin
      w_pc_next = i_next_pc;
    end
  end

  // Moore outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      r_req   <= (w_next_state == S_REQ);
      r_valid <= (w_next_state == S_HOLD);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else if (w_capture) begin
      r_instr    <= i_imem_rdata;
      r_instr_pc <= r_pc;
    end
  end

`ifdef FETCH_CNT_EN
  logic [15:0] r_fetch_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_cnt <= 16'd0;
    end else if (w_consume && (r_fetch_cnt != 16'hFFFF)) begin
      r_fetch_cnt <= r_fetch_cnt + 16'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
`endif

  assign o_pc          = r_pc;
  assign o_imem_addr   = r_pc;
  assign o_imem_req    = r_req;
  assign o_instr_valid = r_valid;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;

endmodule
